// File: rtl/parking_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_gate_pkg : shared gate state encoding and default settings    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package parking_gate_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      OPEN    = 3'd2,
      PASSING = 3'd3,
      DENY    = 3'd4,
      CLEAR   = 3'd5
   } gate_state_t;

   localparam int unsigned DEFAULT_DEBOUNCE_CYC = 4;
   localparam int unsigned DEFAULT_PASS_TIMEOUT = 1000;

endpackage : parking_gate_pkg
`default_nettype wire

// File: rtl/parking_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_debounce : 2-flop synchronizer, stable-sample filter, edges   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module parking_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         // The new level is taken on the DEBOUNCE_CYC-th consecutive differing sample.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule : parking_debounce
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_gate_ctrl : entry/exit lane FSMs, pulse arbiter, pass timeout |
// | Optional feature macro: PARKING_GATE_TIMEOUT_EN                       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module parking_gate_ctrl
   import parking_gate_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
   parameter int unsigned PASS_TIMEOUT = DEFAULT_PASS_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic entry_req,
   input  logic entry_is_uni,
   input  logic entry_pass,
   input  logic exit_req,
   input  logic exit_is_uni,
   input  logic exit_pass,
   input  logic uni_is_vacated_space,
   input  logic is_vacated_space,
   output logic car_entered,
   output logic is_uni_car_entered,
   output logic car_exited,
   output logic is_uni_car_exited,
   output logic entry_gate_open,
   output logic exit_gate_open,
   output logic entry_denied,
   output logic gate_fault
);

   gate_state_t entry_state;
   gate_state_t exit_state;
   logic        entry_uni;
   logic        exit_uni;
   logic        exit_pending;

   logic entry_req_lvl, entry_req_rise, unused_entry_req_fall;
   logic entry_pass_lvl, unused_entry_pass_rise, entry_pass_fall;
   logic exit_req_lvl, exit_req_rise, unused_exit_req_fall;
   logic exit_pass_lvl, unused_exit_pass_rise, exit_pass_fall;

   parking_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_entry_req (
      .clk(clk), .rst_n(rst_n), .din(entry_req),
      .level(entry_req_lvl), .rise(entry_req_rise), .fall(unused_entry_req_fall));
   parking_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_entry_pass (
      .clk(clk), .rst_n(rst_n), .din(entry_pass),
      .level(entry_pass_lvl), .rise(unused_entry_pass_rise), .fall(entry_pass_fall));
   parking_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_exit_req (
      .clk(clk), .rst_n(rst_n), .din(exit_req),
      .level(exit_req_lvl), .rise(exit_req_rise), .fall(unused_exit_req_fall));
   parking_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_exit_pass (
      .clk(clk), .rst_n(rst_n), .din(exit_pass),
      .level(exit_pass_lvl), .rise(unused_exit_pass_rise), .fall(exit_pass_fall));

   logic entry_done;
   logic exit_done;
   logic exit_fire;
   logic entry_admit;
   logic entry_timeout;
   logic exit_timeout;

   assign entry_done  = (entry_state == PASSING) && entry_pass_fall;
   assign exit_done   = (exit_state == PASSING) && exit_pass_fall;
   assign exit_fire   = (exit_pending | exit_done) & ~entry_done;
   assign entry_admit = entry_is_uni ? (uni_is_vacated_space | is_vacated_space)
                                     : is_vacated_space;

`ifdef PARKING_GATE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(PASS_TIMEOUT + 1);

   logic [TO_W-1:0] entry_to_cnt;
   logic [TO_W-1:0] exit_to_cnt;

   // A pass seen in the expiry cycle wins over the timeout.
   assign entry_timeout = (entry_state == OPEN) && !entry_pass_lvl &&
                          (entry_to_cnt == TO_W'(PASS_TIMEOUT - 1));
   assign exit_timeout  = (exit_state == OPEN) && !exit_pass_lvl &&
                          (exit_to_cnt == TO_W'(PASS_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_to_cnt <= '0;
         exit_to_cnt  <= '0;
         gate_fault   <= 1'b0;
      end else begin
         entry_to_cnt <= (entry_state == OPEN) ? entry_to_cnt + TO_W'(1) : '0;
         exit_to_cnt  <= (exit_state == OPEN) ? exit_to_cnt + TO_W'(1) : '0;
         gate_fault   <= gate_fault | entry_timeout | exit_timeout;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^PASS_TIMEOUT;
   assign entry_timeout      = 1'b0;
   assign exit_timeout       = 1'b0;
   assign gate_fault         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_state        <= IDLE;
         exit_state         <= IDLE;
         entry_gate_open    <= 1'b0;
         exit_gate_open     <= 1'b0;
         entry_denied       <= 1'b0;
         entry_uni          <= 1'b0;
         exit_uni           <= 1'b0;
         exit_pending       <= 1'b0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         car_exited         <= 1'b0;
         is_uni_car_exited  <= 1'b0;
      end else begin
         entry_denied <= 1'b0;

         // Entry always wins a same-cycle collision; exit is deferred by one cycle.
         car_entered  <= entry_done;
         car_exited   <= exit_fire;
         exit_pending <= (exit_pending | exit_done) & entry_done;
         if (entry_done) is_uni_car_entered <= entry_uni;
         if (exit_fire)  is_uni_car_exited  <= exit_uni;

         case (entry_state)
            IDLE: if (entry_req_rise) entry_state <= CHECK;
            CHECK: begin
               entry_uni <= entry_is_uni;
               if (entry_admit) begin
                  entry_state     <= OPEN;
                  entry_gate_open <= 1'b1;
               end else begin
                  entry_state  <= DENY;
                  entry_denied <= 1'b1;
               end
            end
            OPEN: begin
               if (entry_pass_lvl) begin
                  entry_state <= PASSING;
               end else if (entry_timeout) begin
                  entry_state     <= CLEAR;
                  entry_gate_open <= 1'b0;
               end
            end
            PASSING: begin
               if (entry_pass_fall) begin
                  entry_state     <= CLEAR;
                  entry_gate_open <= 1'b0;
               end
            end
            DENY, CLEAR: if (!entry_req_lvl) entry_state <= IDLE;
            default: begin
               entry_state     <= IDLE;
               entry_gate_open <= 1'b0;
            end
         endcase

         case (exit_state)
            IDLE: begin
               if (exit_req_rise) begin
                  exit_state     <= OPEN;
                  exit_gate_open <= 1'b1;
                  exit_uni       <= exit_is_uni;
               end
            end
            OPEN: begin
               if (exit_pass_lvl) begin
                  exit_state <= PASSING;
               end else if (exit_timeout) begin
                  exit_state     <= CLEAR;
                  exit_gate_open <= 1'b0;
               end
            end
            PASSING: begin
               if (exit_pass_fall) begin
                  exit_state     <= CLEAR;
                  exit_gate_open <= 1'b0;
               end
            end
            CLEAR: if (!exit_req_lvl) exit_state <= IDLE;
            default: begin
               exit_state     <= IDLE;
               exit_gate_open <= 1'b0;
            end
         endcase
      end
   end

endmodule : parking_gate_ctrl
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parking_gate_ctrl : scoreboard bench for parking_gate_ctrl         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_parking_gate_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic entry_req, entry_is_uni, entry_pass;
   logic exit_req, exit_is_uni, exit_pass;
   logic uni_is_vacated_space, is_vacated_space;
   logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic entry_gate_open, exit_gate_open, entry_denied, gate_fault;

   int total = 0;
   int bad   = 0;

   // kind: 0 = entry pulse, 1 = exit pulse, 2 = denied pulse
   typedef struct packed {
      logic [1:0] kind;
      logic       uni;
   } ev_t;
   ev_t sb[$];

   always #5 clk = ~clk;

   parking_gate_ctrl #(.DEBOUNCE_CYC(4), .PASS_TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n),
      .entry_req(entry_req), .entry_is_uni(entry_is_uni), .entry_pass(entry_pass),
      .exit_req(exit_req), .exit_is_uni(exit_is_uni), .exit_pass(exit_pass),
      .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
      .entry_denied(entry_denied), .gate_fault(gate_fault));

   // Every output pulse must match the oldest outstanding expectation.
   logic prev_e = 1'b0, prev_x = 1'b0;
   always @(negedge clk) begin
      ev_t  e;
      logic hit, u;
      if (rst_n) begin
         if (car_entered && car_exited) begin
            total++; bad++;
            $display("FAIL pulse_overlap entered=%b exited=%b required no overlap", car_entered, car_exited);
         end
         if ((car_entered && prev_e) || (car_exited && prev_x)) begin
            total++; bad++;
            $display("FAIL pulse_width got 2+ cycle pulse required 1 cycle");
         end
         for (int k = 0; k < 3; k++) begin
            hit = (k == 0) ? car_entered : (k == 1) ? car_exited : entry_denied;
            u   = (k == 0) ? is_uni_car_entered : (k == 1) ? is_uni_car_exited : 1'b0;
            if (hit) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL sb_unexpected got kind=%0d uni=%b required no pulse", k, u);
               end else begin
                  e = sb.pop_front();
                  if (e.kind !== 2'(k) || e.uni !== u) begin
                     bad++;
                     $display("FAIL sb_event got kind=%0d uni=%b required kind=%0d uni=%b", k, u, e.kind, e.uni);
                  end
               end
            end
         end
      end
      prev_e = car_entered;
      prev_x = car_exited;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      entry_req = 0; entry_is_uni = 0; entry_pass = 0;
      exit_req = 0; exit_is_uni = 0; exit_pass = 0;
      uni_is_vacated_space = 0; is_vacated_space = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_gate_open, exit_gate_open, entry_denied, gate_fault} !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs got %b%b%b%b%b%b%b%b required 00000000",
                  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                  entry_gate_open, exit_gate_open, entry_denied, gate_fault);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic_entry();
      entry_is_uni = 1; uni_is_vacated_space = 1; is_vacated_space = 0;
      entry_req = 1;
      repeat (7) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b0) begin bad++; $display("FAIL basic_gate_early got %b required 0", entry_gate_open); end
      @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b1) begin bad++; $display("FAIL basic_gate_open got %b required 1", entry_gate_open); end
      entry_pass = 1;
      repeat (10) @(negedge clk);
      entry_pass = 0;
      sb.push_back({2'd0, 1'b1});
      repeat (6) @(negedge clk);
      total++;
      if (car_entered !== 1'b0 || entry_gate_open !== 1'b1) begin
         bad++; $display("FAIL basic_pre_pulse got pulse=%b gate=%b required 0/1", car_entered, entry_gate_open);
      end
      @(negedge clk);
      total++;
      if (car_entered !== 1'b1 || is_uni_car_entered !== 1'b1 || entry_gate_open !== 1'b0) begin
         bad++; $display("FAIL basic_pulse got pulse=%b uni=%b gate=%b required 1/1/0",
                         car_entered, is_uni_car_entered, entry_gate_open);
      end
      @(negedge clk);
      total++;
      if (car_entered !== 1'b0 || is_uni_car_entered !== 1'b1) begin
         bad++; $display("FAIL basic_post_pulse got pulse=%b uni=%b required 0/1", car_entered, is_uni_car_entered);
      end
      entry_req = 0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_vacancy_rules();
      // {is_uni, uni_vacant, general_vacant, admitted}
      logic [3:0] rows [0:4];
      rows[0] = 4'b0111; rows[1] = 4'b1011; rows[2] = 4'b0100;
      rows[3] = 4'b1101; rows[4] = 4'b1000;
      for (int r = 0; r < 5; r++) begin
         entry_is_uni = rows[r][3]; uni_is_vacated_space = rows[r][2]; is_vacated_space = rows[r][1];
         if (!rows[r][0]) sb.push_back({2'd2, 1'b0});
         entry_req = 1;
         repeat (8) @(negedge clk);
         total++;
         if (entry_gate_open !== rows[r][0] || entry_denied !== !rows[r][0]) begin
            bad++; $display("FAIL vacancy_decision row=%0d got gate=%b denied=%b required gate=%b denied=%b",
                            r, entry_gate_open, entry_denied, rows[r][0], !rows[r][0]);
         end
         if (rows[r][0]) begin
            entry_pass = 1;
            repeat (10) @(negedge clk);
            entry_pass = 0;
            sb.push_back({2'd0, rows[r][3]});
            repeat (8) @(negedge clk);
            total++;
            if (is_uni_car_entered !== rows[r][3] || entry_gate_open !== 1'b0) begin
               bad++; $display("FAIL vacancy_class row=%0d got uni=%b gate=%b required uni=%b gate=0",
                               r, is_uni_car_entered, entry_gate_open, rows[r][3]);
            end
         end else begin
            repeat (4) @(negedge clk);
            total++;
            if (entry_gate_open !== 1'b0) begin
               bad++; $display("FAIL vacancy_denied_gate row=%0d got %b required 0", r, entry_gate_open);
            end
         end
         entry_req = 0;
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_exit();
      for (int i = 0; i < 2; i++) begin
         exit_is_uni = (i == 0);
         exit_req = 1;
         repeat (6) @(negedge clk);
         total++;
         if (exit_gate_open !== 1'b0) begin bad++; $display("FAIL exit_gate_early got %b required 0", exit_gate_open); end
         @(negedge clk);
         total++;
         if (exit_gate_open !== 1'b1) begin bad++; $display("FAIL exit_gate_open got %b required 1", exit_gate_open); end
         exit_req = 0;
         repeat (10) @(negedge clk);
         total++;
         if (exit_gate_open !== 1'b1) begin bad++; $display("FAIL exit_req_drop_ignored got %b required 1", exit_gate_open); end
         exit_pass = 1;
         repeat (10) @(negedge clk);
         exit_pass = 0;
         sb.push_back({2'd1, (i == 0)});
         repeat (7) @(negedge clk);
         total++;
         if (car_exited !== 1'b1 || is_uni_car_exited !== (i == 0) || exit_gate_open !== 1'b0) begin
            bad++; $display("FAIL exit_pulse got pulse=%b uni=%b gate=%b required 1/%b/0",
                            car_exited, is_uni_car_exited, exit_gate_open, (i == 0));
         end
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      entry_is_uni = 0; is_vacated_space = 1; exit_is_uni = 1;
      entry_req = 1; exit_req = 1;
      repeat (10) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b1 || exit_gate_open !== 1'b1) begin
         bad++; $display("FAIL b2b_gates got entry=%b exit=%b required 1/1", entry_gate_open, exit_gate_open);
      end
      entry_pass = 1; exit_pass = 1;
      repeat (10) @(negedge clk);
      entry_pass = 0; exit_pass = 0;
      sb.push_back({2'd0, 1'b0});
      sb.push_back({2'd1, 1'b1});
      repeat (7) @(negedge clk);
      total++;
      if (car_entered !== 1'b1 || car_exited !== 1'b0) begin
         bad++; $display("FAIL b2b_cycle_n got entered=%b exited=%b required 1/0", car_entered, car_exited);
      end
      @(negedge clk);
      total++;
      if (car_entered !== 1'b0 || car_exited !== 1'b1 || is_uni_car_exited !== 1'b1) begin
         bad++; $display("FAIL b2b_cycle_n1 got entered=%b exited=%b uni=%b required 0/1/1",
                         car_entered, car_exited, is_uni_car_exited);
      end
      entry_req = 0; exit_req = 0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_glitch();
      int seen_gate, seen_denied;
      entry_is_uni = 0; uni_is_vacated_space = 0; is_vacated_space = 0;
      for (int len = 3; len <= 4; len++) begin
         seen_gate = 0; seen_denied = 0;
         if (len == 4) sb.push_back({2'd2, 1'b0});
         entry_req = 1;
         repeat (len) @(negedge clk);
         entry_req = 0;
         repeat (20) begin
            @(negedge clk);
            if (entry_gate_open) seen_gate++;
            if (entry_denied) seen_denied++;
         end
         total++;
         if (seen_gate != 0 || seen_denied != len - 3) begin
            bad++; $display("FAIL glitch_len%0d got gate_cycles=%0d denied=%0d required 0/%0d",
                            len, seen_gate, seen_denied, len - 3);
         end
      end
   endtask

   task automatic test_timeout();
      entry_is_uni = 0; is_vacated_space = 1;
      entry_req = 1;
      repeat (8) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b1) begin bad++; $display("FAIL to_gate_open got %b required 1", entry_gate_open); end
`ifdef PARKING_GATE_TIMEOUT_EN
      repeat (19) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b1 || gate_fault !== 1'b0) begin
         bad++; $display("FAIL to_before got gate=%b fault=%b required 1/0", entry_gate_open, gate_fault);
      end
      @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b0 || gate_fault !== 1'b1) begin
         bad++; $display("FAIL to_expire got gate=%b fault=%b required 0/1", entry_gate_open, gate_fault);
      end
      entry_req = 0;
      repeat (10) @(negedge clk);
      total++;
      if (gate_fault !== 1'b1) begin bad++; $display("FAIL to_sticky got %b required 1", gate_fault); end
      rst_n = 0;
      #1;
      total++;
      if (gate_fault !== 1'b0) begin bad++; $display("FAIL to_reset_clear got %b required 0", gate_fault); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
`else
      repeat (40) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b1 || gate_fault !== 1'b0) begin
         bad++; $display("FAIL to_disabled got gate=%b fault=%b required 1/0", entry_gate_open, gate_fault);
      end
      entry_pass = 1;
      repeat (10) @(negedge clk);
      entry_pass = 0;
      sb.push_back({2'd0, 1'b0});
      repeat (8) @(negedge clk);
      total++;
      if (entry_gate_open !== 1'b0) begin bad++; $display("FAIL to_disabled_close got %b required 0", entry_gate_open); end
      entry_req = 0;
      repeat (10) @(negedge clk);
`endif
   endtask

   task automatic test_reset_midop();
      exit_is_uni = 0;
      exit_req = 1;
      repeat (8) @(negedge clk);
      total++;
      if (exit_gate_open !== 1'b1) begin bad++; $display("FAIL midrst_open got %b required 1", exit_gate_open); end
      exit_pass = 1;
      repeat (7) @(negedge clk);
      #2 rst_n = 0;
      #1;
      total++;
      if (exit_gate_open !== 1'b0) begin bad++; $display("FAIL midrst_async_close got %b required 0", exit_gate_open); end
      exit_req = 0; exit_pass = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);
      total++;
      if ({car_entered, car_exited, entry_gate_open, exit_gate_open, entry_denied, gate_fault} !== 6'b0) begin
         bad++; $display("FAIL midrst_quiet got %b%b%b%b%b%b required 000000",
                         car_entered, car_exited, entry_gate_open, exit_gate_open, entry_denied, gate_fault);
      end
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_vacancy_rules();
      test_exit();
      test_back_to_back();
      test_glitch();
      test_timeout();
      test_reset_midop();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_leftover got %0d pending events required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_parking_gate_ctrl
`default_nettype wire
